// File: rtl/ddr_pkg.sv
// ============================================================================
// Module  : ddr_pkg
// Brief   : Button indices and channel FSM state encoding shared by the
//           button conditioner and its per-channel debouncer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ddr_pkg;

  localparam int BTN_U    = 0;
  localparam int BTN_D    = 1;
  localparam int BTN_L    = 2;
  localparam int BTN_R    = 3;
  localparam int BTN_M    = 4;
  localparam int NUM_BTNS = 5;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module  : btn_debounce_ch
// Brief   : One push-button channel: 2-flop synchroniser, debounce FSM and
//           registered level/press/release outputs. Optional auto-repeat of
//           the press pulse while held is enabled by BTN_AUTOREPEAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce_ch
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sync_s;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE       = RPT_W'(1);

  // Down-counter: reaching zero while still held fires the next repeat.
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign sync_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], i_btn};
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d     = rpt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sync_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!sync_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rpt_d   = RPT_DELAY_LD;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!sync_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
          rpt_d   = '0;
        end else if (rpt_q == '0) begin
          press_d = 1'b1;
          rpt_d   = RPT_PERIOD_LD;
        end else begin
          rpt_d   = rpt_q - RPT_ONE;
`endif
        end
      end

      ST_RELEASE_WAIT: begin
        if (sync_s) begin
          state_d = ST_HELD;
`ifdef BTN_AUTOREPEAT_EN
          rpt_d   = RPT_DELAY_LD;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module  : btn_conditioner
// Brief   : Five-button front end: per-button synchronise, debounce and
//           press/release pulse generation. BTN_AUTOREPEAT_EN adds auto-repeat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_conditioner
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                BtnU,
  input  logic                BtnD,
  input  logic                BtnL,
  input  logic                BtnR,
  input  logic                BtnM,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  logic [NUM_BTNS-1:0] btn_raw;

  always_comb begin
    btn_raw        = '0;
    btn_raw[BTN_U] = BtnU;
    btn_raw[BTN_D] = BtnD;
    btn_raw[BTN_L] = BtnL;
    btn_raw[BTN_R] = BtnR;
    btn_raw[BTN_M] = BtnM;
  end

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (btn_raw[i]),
      .o_level   (btn_level[i]),
      .o_press   (btn_press[i]),
      .o_release (btn_release[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module  : tb_btn_conditioner
// Brief   : Directed and randomised bench for btn_conditioner against a
//           run-length reference model; honours BTN_AUTOREPEAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_btn_conditioner;

  localparam int DEB  = 16;
  localparam int RDLY = 64;
  localparam int RPER = 32;
  localparam int NB   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .BtnU        (raw[0]),
    .BtnD        (raw[1]),
    .BtnL        (raw[2]),
    .BtnR        (raw[3]),
    .BtnM        (raw[4]),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  // Reference: a level flips once DEB+1 consecutive synchronised samples disagree with it.
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0, m_smp;
  int            m_run [NB];
  int            m_age [NB];

`ifdef BTN_AUTOREPEAT_EN
  function automatic bit repeat_due(input int age);
    return (age == RDLY) || (age > RDLY && ((age - RDLY) % RPER) == 0);
  endfunction
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_age[i] = 0; end
    end else begin
      m_smp = m_s2; m_s2 = m_s1; m_s1 = raw;
      m_press = '0; m_rel = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_smp[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i] = m_smp[i];
            m_run[i] = 0;
            if (m_smp[i]) begin m_press[i] = 1'b1; m_age[i] = 0; end
            else m_rel[i] = 1'b1;
          end
        end else begin
          if (m_lvl[i]) begin
            if (m_run[i] == 0) begin
              m_age[i]++;
`ifdef BTN_AUTOREPEAT_EN
              if (repeat_due(m_age[i])) m_press[i] = 1'b1;
`endif
            end else begin
              m_age[i] = 0;
            end
          end
          m_run[i] = 0;
        end
      end
    end
  end

  int n_chk = 0, n_pass = 0, cyc = 0;
  int press_cnt [NB], rel_cnt [NB], first_press [NB], first_rel [NB], lvl_seen [NB];
  int rm_seen;
  int press_cyc4 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clr();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; first_press[i] = -1; first_rel[i] = -1; lvl_seen[i] = 0;
    end
    rm_seen = 0;
    press_cyc4.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("level_vs_model",   32'(btn_level),   32'(m_lvl));
    check("press_vs_model",   32'(btn_press),   32'(m_press));
    check("release_vs_model", 32'(btn_release), 32'(m_rel));
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i]) begin
        press_cnt[i]++;
        if (first_press[i] < 0) first_press[i] = cyc;
        if (i == 4) press_cyc4.push_back(cyc);
      end
      if (btn_release[i]) begin
        rel_cnt[i]++;
        if (first_rel[i] < 0) first_rel[i] = cyc;
      end
      if (btn_level[i]) lvl_seen[i]++;
    end
    if (btn_press == 5'b11000) rm_seen++;
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int start;
    int pre;
    int hold_left [NB];
    int offs [5];
    offs = '{0, 64, 96, 128, 160};
    clr();

    // Reset state
    rst = 1'b1;
    hold(3);
    check("rst_level",   32'(btn_level),   32'd0);
    check("rst_press",   32'(btn_press),   32'd0);
    check("rst_release", 32'(btn_release), 32'd0);
    rst = 1'b0;
    hold(8);

    // BtnU press/release latency
    clr();
    raw[0] = 1'b1;
    start  = cyc + 1;
    hold(30);
    check("u_press_count",   32'(press_cnt[0]), 32'd1);
    check("u_press_latency", 32'(first_press[0] - start), 32'(DEB + 2));
    check("u_level_held",    32'(btn_level[0]), 32'd1);
    raw[0] = 1'b0;
    start  = cyc + 1;
    hold(30);
    check("u_release_count",   32'(rel_cnt[0]), 32'd1);
    check("u_release_latency", 32'(first_rel[0] - start), 32'(DEB + 2));

    // BtnL glitch shorter than the debounce window
    clr();
    raw[2] = 1'b1;
    hold(10);
    raw[2] = 1'b0;
    hold(30);
    check("l_glitch_press",   32'(press_cnt[2]), 32'd0);
    check("l_glitch_release", 32'(rel_cnt[2]),   32'd0);
    check("l_glitch_level",   32'(lvl_seen[2]),  32'd0);

    // BtnD bounce before release
    clr();
    raw[1] = 1'b1;
    hold(25);
    for (int b = 0; b < 5; b++) begin
      raw[1] = 1'b0; hold(3);
      raw[1] = 1'b1; hold(3);
    end
    raw[1] = 1'b0;
    hold(30);
    check("d_bounce_press",   32'(press_cnt[1]), 32'd1);
    check("d_bounce_release", 32'(rel_cnt[1]),   32'd1);

    // BtnR and BtnM together
    clr();
    raw[3] = 1'b1; raw[4] = 1'b1;
    hold(25);
    check("rm_same_cycle", 32'(rm_seen), 32'd1);
    raw[3] = 1'b0; raw[4] = 1'b0;
    hold(25);
    check("rm_release_r", 32'(rel_cnt[3]), 32'd1);
    check("rm_release_m", 32'(rel_cnt[4]), 32'd1);

    // Reset while BtnU is debouncing and kept held
    clr();
    raw[0] = 1'b1;
    hold(8);
    pre = press_cnt[0];
    rst = 1'b1;
    hold(3);
    check("rst_mid_press",  32'(press_cnt[0] - pre), 32'd0);
    check("rst_mid_level",  32'(btn_level[0]),       32'd0);
    clr();
    rst   = 1'b0;
    start = cyc + 1;
    hold(30);
    check("post_rst_count",   32'(press_cnt[0]), 32'd1);
    check("post_rst_latency", 32'(first_press[0] - start), 32'(DEB + 2));
    raw[0] = 1'b0;
    hold(25);

    // BtnM long hold
    clr();
    raw[4] = 1'b1;
    hold(200);
    raw[4] = 1'b0;
    hold(25);
`ifdef BTN_AUTOREPEAT_EN
    check("m_repeat_count", 32'(press_cnt[4]), 32'd5);
    if (press_cyc4.size() == 5) begin
      for (int k = 0; k < 5; k++)
        check("m_repeat_offset", 32'(press_cyc4[k] - press_cyc4[0]), 32'(offs[k]));
    end
`else
    check("m_single_press", 32'(press_cnt[4]), 32'd1);
`endif
    check("m_single_release", 32'(rel_cnt[4]), 32'd1);

    // Randomised toggling with short glitches and one mid-run reset
    for (int i = 0; i < NB; i++) hold_left[i] = int'($urandom_range(1, 40));
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          raw[i] = ~raw[i];
          if ($urandom_range(0, 3) == 0) hold_left[i] = int'($urandom_range(1, 5));
          else                           hold_left[i] = int'($urandom_range(10, 45));
        end else begin
          hold_left[i]--;
        end
      end
      if (c == 700) rst = 1'b1;
      if (c == 703) rst = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
